// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered pad drive (push-pull/open-drain), synchronized and
// debounced inputs, edge pulses and sticky interrupts. Define GPIO_PAD_CTRL_DEBOUNCE_EN for debounce counters.
module gpio_pad_ctrl #(
  parameter int NUM_PIN = 8,
  parameter int DEB_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_PIN-1:0] out_i,
  input  logic [NUM_PIN-1:0] oe_i,
  input  logic [NUM_PIN-1:0] od_i,
  output logic [NUM_PIN-1:0] c2p_o,
  output logic [NUM_PIN-1:0] c2p_en_o,
  input  logic [NUM_PIN-1:0] p2c_i,
  input  logic [DEB_W-1:0]   deb_thr_i,
  output logic [NUM_PIN-1:0] in_o,
  output logic [NUM_PIN-1:0] rise_o,
  output logic [NUM_PIN-1:0] fall_o,
  input  logic [NUM_PIN-1:0] rise_ie_i,
  input  logic [NUM_PIN-1:0] fall_ie_i,
  input  logic [NUM_PIN-1:0] irq_clr_i,
  output logic [NUM_PIN-1:0] irq_pend_o,
  output logic               irq_o
);

  logic [NUM_PIN-1:0] sync_q1;
  logic [NUM_PIN-1:0] sync_q2;
  logic [NUM_PIN-1:0] stable_q;
  logic [NUM_PIN-1:0] stable_nxt;

  // Open-drain pins never drive high: a logic 1 releases the pad.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c2p_o    <= '0;
      c2p_en_o <= '0;
    end else begin
      c2p_o    <= out_i & ~od_i;
      c2p_en_o <= oe_i & ~(od_i & out_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= p2c_i;
      sync_q2 <= sync_q1;
    end
  end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  logic [DEB_W-1:0] cnt_q   [NUM_PIN];
  logic [DEB_W-1:0] cnt_nxt [NUM_PIN];

  // >= rather than == so a threshold lowered mid-count still takes effect.
  always_comb begin
    stable_nxt = stable_q;
    for (int i = 0; i < NUM_PIN; i++) begin
      cnt_nxt[i] = '0;
      if (sync_q2[i] != stable_q[i]) begin
        if (cnt_q[i] >= deb_thr_i) begin
          stable_nxt[i] = sync_q2[i];
        end else if (cnt_q[i] != '1) begin
          cnt_nxt[i] = cnt_q[i] + DEB_W'(1);
        end else begin
          cnt_nxt[i] = cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_nxt;
    end
  end
`else
  logic unused_deb_thr;

  assign stable_nxt     = sync_q2;
  assign unused_deb_thr = ^deb_thr_i;
`endif

  // Edge pulses are registered alongside stable so they coincide with the new in_o level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
    end else begin
      stable_q <= stable_nxt;
      rise_o   <= stable_nxt & ~stable_q;
      fall_o   <= ~stable_nxt & stable_q;
    end
  end

  // A new event wins over a clear strobe in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_pend_o <= '0;
    end else begin
      irq_pend_o <= (irq_pend_o & ~irq_clr_i) | (rise_o & rise_ie_i) | (fall_o & fall_ie_i);
    end
  end

  assign in_o  = stable_q;
  assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: expectations are queued with a due cycle when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_gpio_pad_ctrl;

  localparam int NP = 8;
  localparam int DW = 16;

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  localparam int S_C2P  = 0;
  localparam int S_EN   = 1;
  localparam int S_IN   = 2;
  localparam int S_RISE = 3;
  localparam int S_FALL = 4;
  localparam int S_PEND = 5;
  localparam int S_IRQ  = 6;

  logic          clk;
  logic          rst;
  logic [NP-1:0] out_v, oe_v, od_v, p2c_v, rise_ie, fall_ie, irq_clr;
  logic [DW-1:0] deb_thr;
  logic [NP-1:0] c2p, c2p_en, in_v, rise, fall, irq_pend;
  logic          irq;

  gpio_pad_ctrl #(.NUM_PIN(NP), .DEB_W(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .out_i      (out_v),
    .oe_i       (oe_v),
    .od_i       (od_v),
    .c2p_o      (c2p),
    .c2p_en_o   (c2p_en),
    .p2c_i      (p2c_v),
    .deb_thr_i  (deb_thr),
    .in_o       (in_v),
    .rise_o     (rise),
    .fall_o     (fall),
    .rise_ie_i  (rise_ie),
    .fall_ie_i  (fall_ie),
    .irq_clr_i  (irq_clr),
    .irq_pend_o (irq_pend),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] mask;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int sig);
    case (sig)
      S_C2P:   return 32'(c2p);
      S_EN:    return 32'(c2p_en);
      S_IN:    return 32'(in_v);
      S_RISE:  return 32'(rise);
      S_FALL:  return 32'(fall);
      S_PEND:  return 32'(irq_pend);
      default: return 32'(irq);
    endcase
  endfunction

  function automatic int lat(input int thr);
    return DEB_ON ? 3 + thr : 3;
  endfunction

  task automatic push(input int dly, input int sig, input logic [31:0] mask,
                      input logic [31:0] val, input string tag);
    exp_t e;
    e.at   = cyc + dly;
    e.sig  = sig;
    e.mask = mask;
    e.val  = val & mask;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic pin_exp(input int dly, input int sig, input int pin, input logic v,
                         input string tag);
    push(dly, sig, 32'(1) << pin, 32'(v) << pin, tag);
  endtask

  task automatic all_zero(input int dly, input string tag);
    for (int s = S_C2P; s <= S_IRQ; s++) begin
      push(dly, s, (s == S_IRQ) ? 32'h1 : 32'hFF, 32'h0, tag);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_val(sb[i].tag, obs_of(sb[i].sig) & sb[i].mask, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int l4;

  initial begin
    rst = 1'b1;
    out_v = '0; oe_v = '0; od_v = '0; p2c_v = '0;
    rise_ie = '0; fall_ie = '0; irq_clr = '0; deb_thr = '0;
    l4 = lat(4);

    // Reset holds pads as inputs even with drive requested.
    tick();
    out_v = '1; oe_v = '1;
    all_zero(1, "rst_hold");
    ticks(2);
    rst = 1'b0; out_v = '0; oe_v = '0;
    ticks(3);

    // Open-drain and push-pull drive.
    od_v[0] = 1'b1; oe_v[0] = 1'b1; out_v[0] = 1'b0;
    pin_exp(1, S_C2P, 0, 1'b0, "od_low_c2p");
    pin_exp(1, S_EN,  0, 1'b1, "od_low_en");
    tick();
    out_v[0] = 1'b1;
    pin_exp(1, S_C2P, 0, 1'b0, "od_high_c2p");
    pin_exp(1, S_EN,  0, 1'b0, "od_high_en");
    tick();
    oe_v[5] = 1'b1; out_v[5] = 1'b1;
    pin_exp(1, S_C2P, 5, 1'b1, "pp_high_c2p");
    pin_exp(1, S_EN,  5, 1'b1, "pp_high_en");
    tick();
    out_v[5] = 1'b0;
    pin_exp(1, S_C2P, 5, 1'b0, "pp_low_c2p");
    pin_exp(1, S_EN,  5, 1'b1, "pp_low_en");
    tick();
    oe_v[5] = 1'b0;
    pin_exp(1, S_EN, 5, 1'b0, "pp_off_en");
    ticks(2);

    // Clean rising transition on pin 1.
    deb_thr = 16'd4;
    p2c_v[1] = 1'b1;
    pin_exp(l4 - 1, S_IN,   1, 1'b0, "deb_early");
    pin_exp(l4,     S_IN,   1, 1'b1, "deb_in");
    pin_exp(l4,     S_RISE, 1, 1'b1, "deb_rise");
    pin_exp(l4,     S_FALL, 1, 1'b0, "deb_no_fall");
    pin_exp(l4 + 1, S_RISE, 1, 1'b0, "deb_rise_end");
    pin_exp(l4 + 1, S_IN,   1, 1'b1, "deb_hold");
    pin_exp(l4 + 1, S_PEND, 1, 1'b0, "deb_rise_masked");
    ticks(l4 + 3);

    // Three-cycle glitch on pin 2.
    p2c_v[2] = 1'b1;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    for (int d = 1; d <= 10; d++) begin
      pin_exp(d, S_IN,   2, 1'b0, "glitch_in");
      pin_exp(d, S_RISE, 2, 1'b0, "glitch_rise");
      pin_exp(d, S_FALL, 2, 1'b0, "glitch_fall");
    end
`else
    pin_exp(2, S_IN,   2, 1'b0, "glitch_early");
    pin_exp(3, S_IN,   2, 1'b1, "glitch_in");
    pin_exp(3, S_RISE, 2, 1'b1, "glitch_rise");
    pin_exp(6, S_IN,   2, 1'b0, "glitch_back");
    pin_exp(6, S_FALL, 2, 1'b1, "glitch_fall");
`endif
    ticks(3);
    p2c_v[2] = 1'b0;
    ticks(10);

    // Falling-edge interrupt on pin 3, and set beating clear.
    fall_ie[3] = 1'b1;
    p2c_v[3] = 1'b1;
    pin_exp(l4,     S_IN,   3, 1'b1, "p3_up");
    pin_exp(l4 + 1, S_PEND, 3, 1'b0, "p3_rise_ignored");
    ticks(l4 + 2);
    p2c_v[3] = 1'b0;
    pin_exp(l4,     S_FALL, 3, 1'b1, "p3_fall");
    pin_exp(l4 + 1, S_PEND, 3, 1'b1, "p3_pend");
    push(l4 + 1, S_IRQ, 32'h1, 32'h1, "irq_set");
    ticks(l4 + 2);
    p2c_v[3] = 1'b1;
    ticks(l4 + 2);
    pin_exp(0, S_PEND, 3, 1'b1, "p3_pend_hold");
    tick();
    p2c_v[3] = 1'b0;
    pin_exp(l4, S_FALL, 3, 1'b1, "p3_fall2");
    ticks(l4);
    irq_clr[3] = 1'b1;
    pin_exp(1, S_PEND, 3, 1'b1, "set_beats_clr");
    tick();
    irq_clr = '0;
    ticks(2);
    irq_clr[3] = 1'b1;
    pin_exp(1, S_PEND, 3, 1'b0, "p3_clr");
    push(1, S_IRQ, 32'h1, 32'h0, "irq_clr");
    tick();
    irq_clr = '0;
    tick();

    // Simultaneous events on pins 6 and 7.
    rise_ie[7:6] = 2'b11;
    p2c_v[7:6] = 2'b11;
    push(l4,     S_RISE, 32'hC0, 32'hC0, "multi_rise");
    push(l4 + 1, S_PEND, 32'hC0, 32'hC0, "multi_pend");
    ticks(l4 + 2);
    irq_clr = 8'h40;
    push(1, S_PEND, 32'hC0, 32'h80, "multi_clr");
    push(1, S_IRQ, 32'h1, 32'h1, "irq_still");
    tick();
    irq_clr = '0;
    tick();

    // Reset in the middle of a pin-4 debounce.
    od_v = '0; oe_v = '1; out_v = '1;
    push(1, S_C2P, 32'hFF, 32'hFF, "pp_all_c2p");
    ticks(2);
    p2c_v[4] = 1'b1;
    ticks(4);
    rst = 1'b1;
    all_zero(1, "rst_mid");
    all_zero(2, "rst_mid2");
    ticks(2);
    rst = 1'b0;
    pin_exp(l4 - 1, S_IN,   4, 1'b0, "rst_cnt_discard");
    pin_exp(l4,     S_IN,   4, 1'b1, "rst_in");
    pin_exp(l4,     S_RISE, 4, 1'b1, "rst_rise");
    pin_exp(l4,     S_RISE, 1, 1'b1, "rst_pad_high_rise");
    push(1, S_C2P, 32'hFF, 32'hFF, "rst_exit_c2p");
    ticks(l4 + 3);

    ticks(5);
    check_val("sb_drain", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
